// File: rtl/sfp_acc.sv
// sfp_acc: per-pixel saturating accumulator bank behind the output FIFO.
// Each entry gathers npass partial-sum vectors, then is read out with optional ReLU.
module sfp_acc #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 16,
  parameter int unsigned npass   = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [psum_bw*col-1:0]     in,
  input  logic                       in_valid,
  input  logic [$clog2(depth)-1:0]   wr_addr,
  input  logic                       first,
  input  logic                       rd,
  input  logic [$clog2(depth)-1:0]   rd_addr,
  input  logic                       rd_clr,
  input  logic                       relu_en,
  output logic [psum_bw*col-1:0]     out,
  output logic                       out_valid,
  output logic [depth-1:0]           o_done,
  output logic                       o_err
);

  localparam logic [7:0] npass_c = 8'(npass);

  logic [psum_bw*col-1:0] val_q [depth];
  logic [7:0]             cnt_q [depth];
  logic [depth-1:0]       done_q;
  logic [psum_bw*col-1:0] out_q;
  logic                   out_valid_q;
  logic                   err_q;

  logic [psum_bw*col-1:0] wr_cur, wr_sum, wr_val;
  logic [psum_bw*col-1:0] rd_cur, rd_data;
  logic [7:0]             cnt_next;
  logic                   clash, wr_en, wr_err, rd_err, do_clr;

  // Signed add one bit wider, then clamp to the lane range.
  function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1]) begin
      sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      sat_add = s[psum_bw-1:0];
    end
  endfunction

  // Per-lane sums for the write port and ReLU-filtered data for the read port.
  always_comb begin
    wr_cur  = val_q[wr_addr];
    rd_cur  = val_q[rd_addr];
    wr_sum  = '0;
    rd_data = '0;
    for (int k = 0; k < int'(col); k++) begin
      wr_sum[k*psum_bw +: psum_bw] = sat_add(wr_cur[k*psum_bw +: psum_bw],
                                             in[k*psum_bw +: psum_bw]);
      if (relu_en && rd_cur[(k+1)*psum_bw-1]) begin
        rd_data[k*psum_bw +: psum_bw] = '0;
      end else begin
        rd_data[k*psum_bw +: psum_bw] = rd_cur[k*psum_bw +: psum_bw];
      end
    end
  end

  // Write/read decode; a same-entry read-with-clear beats the write.
  always_comb begin
    do_clr   = rd & rd_clr;
    clash    = in_valid & do_clr & (rd_addr == wr_addr);
    wr_en    = in_valid & ~clash & (first | ~done_q[wr_addr]);
    wr_err   = in_valid & (clash | (~first & done_q[wr_addr]));
    rd_err   = rd & ~done_q[rd_addr];
    wr_val   = first ? in : wr_sum;
    cnt_next = first ? 8'd1 : cnt_q[wr_addr] + 8'd1;
  end

  // Entry bank, read register and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(depth); i++) begin
        val_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      done_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (wr_en) begin
        val_q[wr_addr]  <= wr_val;
        cnt_q[wr_addr]  <= cnt_next;
        done_q[wr_addr] <= (cnt_next == npass_c);
      end
      if (rd) begin
        out_q       <= rd_data;
        out_valid_q <= done_q[rd_addr];
      end else begin
        out_valid_q <= 1'b0;
      end
      if (do_clr) begin
        val_q[rd_addr]  <= '0;
        cnt_q[rd_addr]  <= '0;
        done_q[rd_addr] <= 1'b0;
      end
      if (wr_err || rd_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_sfp_acc.sv
// Bench for sfp_acc: directed vector table, async-reset check, then random ops vs a model.
module tb_sfp_acc;
  localparam int COL = 8, BW = 16, DEPTH = 16, NPASS = 3, AW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [BW*COL-1:0] in_v;
  logic              iv, fi, rdv, rcv, re;
  logic [AW-1:0]     wa, ra;
  logic [BW*COL-1:0] out;
  logic              out_valid;
  logic [DEPTH-1:0]  o_done;
  logic              o_err;

  sfp_acc #(.col(COL), .psum_bw(BW), .depth(DEPTH), .npass(NPASS)) dut (
    .clk(clk), .reset(reset), .in(in_v), .in_valid(iv), .wr_addr(wa), .first(fi),
    .rd(rdv), .rd_addr(ra), .rd_clr(rcv), .relu_en(re), .out(out), .out_valid(out_valid),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int drv[COL];

  // Reference model state
  int m_val[DEPTH][COL];
  int m_cnt[DEPTH];
  bit m_done[DEPTH];
  bit m_err;
  int m_out[COL];
  bit m_ov;

  typedef struct {
    bit iv, fi; int wa, l0, l1;
    bit rd, rc, re; int ra;
    int e0, e1; bit ev; logic [15:0] ed; bit ee;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit iv_, bit fi_, int wa_, int l0_, int l1_, bit rd_, bit rc_,
                              bit re_, int ra_, int e0_, int e1_, bit ev_, logic [15:0] ed_,
                              bit ee_);
    vec_t v;
    v.iv = iv_; v.fi = fi_; v.wa = wa_; v.l0 = l0_; v.l1 = l1_;
    v.rd = rd_; v.rc = rc_; v.re = re_; v.ra = ra_;
    v.e0 = e0_; v.e1 = e1_; v.ev = ev_; v.ed = ed_; v.ee = ee_;
    return v;
  endfunction

  function automatic int lane(int k);
    logic signed [BW-1:0] s;
    s = out[k*BW +: BW];
    return int'(s);
  endfunction

  function automatic int clamp(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pack_drv();
    for (int k = 0; k < COL; k++) in_v[k*BW +: BW] = 16'(drv[k]);
  endtask

  // Applies the documented rules for one clock edge using the current inputs.
  task automatic model_step();
    int w, r;
    bit clash;
    w = int'(wa);
    r = int'(ra);
    clash = iv && rdv && rcv && (w == r);
    if (rdv) begin
      for (int k = 0; k < COL; k++) m_out[k] = (re && m_val[r][k] < 0) ? 0 : m_val[r][k];
      m_ov = m_done[r];
      if (!m_done[r]) m_err = 1;
    end else begin
      m_ov = 0;
    end
    if (iv) begin
      if (clash) m_err = 1;
      else if (fi) begin
        for (int k = 0; k < COL; k++) m_val[w][k] = drv[k];
        m_cnt[w] = 1;
        m_done[w] = (NPASS == 1);
      end else if (m_done[w]) m_err = 1;
      else begin
        for (int k = 0; k < COL; k++) m_val[w][k] = clamp(m_val[w][k] + drv[k]);
        m_cnt[w]++;
        m_done[w] = (m_cnt[w] == NPASS);
      end
    end
    if (rdv && rcv) begin
      for (int k = 0; k < COL; k++) m_val[r][k] = 0;
      m_cnt[r] = 0;
      m_done[r] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < COL; k++) m_val[i][k] = 0;
      m_cnt[i] = 0;
      m_done[i] = 0;
    end
    for (int k = 0; k < COL; k++) m_out[k] = 0;
    m_err = 0;
    m_ov = 0;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < COL; k++) drv[k] = 0;
    pack_drv();
    iv = 0; fi = 0; wa = '0; rdv = 0; rcv = 0; re = 0; ra = '0;
  endtask

  initial begin
    logic [DEPTH-1:0] exp_done;
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset out", longint'(out[63:0]), 0);
    check("reset out_valid", out_valid, 0);
    check("reset o_done", o_done, 0);
    check("reset o_err", o_err, 0);

    //         iv fi wa  l0     l1      rd rc re ra  e0     e1      ev ed     ee
    tbl.push_back(mk(1, 1, 2, 5, 0,          0, 0, 0, 0, 0, 0,          0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 2, 7, 0,          0, 0, 0, 0, 0, 0,          0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 2, -2, 0,         0, 0, 0, 0, 0, 0,          0, 16'h0004, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 2, 10, 0,         1, 16'h0004, 0));
    tbl.push_back(mk(1, 1, 3, 32000, -32000, 0, 0, 0, 0, 10, 0,         0, 16'h0004, 0));
    tbl.push_back(mk(1, 0, 3, 1000, -1000,   0, 0, 0, 0, 10, 0,         0, 16'h0004, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0,          0, 0, 0, 0, 10, 0,         0, 16'h000C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 3, 32767, -32768, 1, 16'h000C, 0));
    tbl.push_back(mk(1, 1, 4, -4, 9,         1, 0, 1, 3, 32767, 0,      1, 16'h000C, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0,          0, 0, 0, 0, 32767, 0,      0, 16'h000C, 0));
    tbl.push_back(mk(1, 0, 4, 0, 0,          0, 0, 0, 0, 32767, 0,      0, 16'h001C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 1, 4, 0, 9,          1, 16'h001C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 4, -4, 9,         1, 16'h001C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 1, 0, 3, 32767, -32768, 1, 16'h0014, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 3, 0, 0,          0, 16'h0014, 1));
    tbl.push_back(mk(1, 0, 4, 100, 100,      0, 0, 0, 0, 0, 0,          0, 16'h0014, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 4, -4, 9,         1, 16'h0014, 1));
    tbl.push_back(mk(1, 1, 4, 1, 2,          0, 0, 0, 0, -4, 9,         0, 16'h0004, 1));
    tbl.push_back(mk(1, 1, 5, 20, 0,         0, 0, 0, 0, -4, 9,         0, 16'h0004, 1));
    tbl.push_back(mk(1, 0, 5, 5, 0,          1, 0, 0, 5, 20, 0,         0, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 5, 25, 0,         0, 16'h0004, 1));
    tbl.push_back(mk(1, 1, 6, 7, 7,          0, 0, 0, 0, 25, 0,         0, 16'h0004, 1));
    tbl.push_back(mk(1, 0, 6, 1, 1,          1, 1, 0, 6, 7, 7,          0, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 6, 0, 0,          0, 16'h0004, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,          1, 0, 0, 2, 10, 0,         1, 16'h0004, 1));

    foreach (tbl[i]) begin
      for (int k = 0; k < COL; k++) drv[k] = 0;
      drv[0] = tbl[i].l0;
      drv[1] = tbl[i].l1;
      pack_drv();
      iv = tbl[i].iv; fi = tbl[i].fi; wa = AW'(tbl[i].wa);
      rdv = tbl[i].rd; rcv = tbl[i].rc; re = tbl[i].re; ra = AW'(tbl[i].ra);
      @(posedge clk);
      #1;
      check($sformatf("row%0d lane0", i), lane(0), tbl[i].e0);
      check($sformatf("row%0d lane1", i), lane(1), tbl[i].e1);
      check($sformatf("row%0d out_valid", i), out_valid, tbl[i].ev);
      check($sformatf("row%0d o_done", i), o_done, tbl[i].ed);
      check($sformatf("row%0d o_err", i), o_err, tbl[i].ee);
    end

    // Asynchronous reset mid-cycle: outputs clear before any further clock edge.
    idle_inputs();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async reset out", longint'(out[63:0]), 0);
    check("async reset o_done", o_done, 0);
    check("async reset o_err", o_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Randomised traffic on a few entries to provoke collisions and saturation.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < COL; k++) begin
        if ($urandom_range(0, 3) == 0) drv[k] = int'($urandom_range(0, 65535)) - 32768;
        else drv[k] = int'($urandom_range(0, 200)) - 100;
      end
      pack_drv();
      iv  = ($urandom_range(0, 3) != 0);
      fi  = ($urandom_range(0, 3) == 0);
      wa  = AW'($urandom_range(0, 3));
      rdv = ($urandom_range(0, 2) == 0);
      rcv = ($urandom_range(0, 7) == 0);
      re  = $urandom_range(0, 1) == 1;
      ra  = AW'($urandom_range(0, 3));
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < COL; k++) check($sformatf("rand%0d lane%0d", c, k), lane(k), m_out[k]);
      check($sformatf("rand%0d out_valid", c), out_valid, m_ov);
      exp_done = '0;
      for (int i = 0; i < DEPTH; i++) exp_done[i] = m_done[i];
      check($sformatf("rand%0d o_done", c), o_done, exp_done);
      check($sformatf("rand%0d o_err", c), o_err, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
